// File: rtl/alarm_trigger.sv
// Alarm decision FSM: compares the stored alarm (or snooze target) with the running time and drives start.
// Latency: a match rise in cycle N gives start=1 in cycle N+1; alarm_* update the cycle after set_en.
// Backpressure: none; stop/snooze/set_en are single-cycle pulses and are always accepted.
module alarm_trigger #(
  parameter int RING_CYCLES     = 500_000_000,
  parameter int RING_WIDTH      = $clog2(RING_CYCLES),
  parameter int SNOOZE_MINUTES  = 5,
  parameter int DEFAULT_HOURS   = 6,
  parameter int DEFAULT_MINUTES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  input  logic [5:0] cur_seconds,
  input  logic       set_en,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic       arm,
  input  logic       stop,
  input  logic       snooze,
  output logic       start,
  output logic       armed,
  output logic       snoozing,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes
);

  typedef enum logic [1:0] {DISARMED, ARMED, RINGING, SNOOZE} state_t;

  state_t                state, state_nxt;
  logic [4:0]            snz_hours;
  logic [5:0]            snz_minutes;
  logic [RING_WIDTH-1:0] ring_cnt;
  logic                  match, match_q, match_rise;
  logic [4:0]            tgt_hours;
  logic [5:0]            tgt_minutes;
  logic [6:0]            snz_min_sum;
  logic [4:0]            snz_hours_nxt;
  logic [5:0]            snz_minutes_nxt;
  logic                  ring_done;
  logic                  set_ok;

  // Outside SNOOZE the alarm time stays the target, so match_q remains high
  // through the matching second after stop/timeout and blocks a re-ring.
  always_comb begin
    tgt_hours   = alarm_hours;
    tgt_minutes = alarm_minutes;
    if (state == SNOOZE) begin
      tgt_hours   = snz_hours;
      tgt_minutes = snz_minutes;
    end
  end

  assign match      = (cur_hours == tgt_hours) && (cur_minutes == tgt_minutes) && (cur_seconds == 6'd0);
  assign match_rise = match && !match_q;
  assign ring_done  = (ring_cnt == RING_WIDTH'(RING_CYCLES - 1));
  assign set_ok     = (set_hours <= 5'd23) && (set_minutes <= 6'd59);

  always_comb begin
    snz_min_sum     = {1'b0, cur_minutes} + 7'(SNOOZE_MINUTES);
    snz_hours_nxt   = cur_hours;
    snz_minutes_nxt = snz_min_sum[5:0];
    if (snz_min_sum >= 7'd60) begin
      snz_minutes_nxt = 6'(snz_min_sum - 7'd60);
      snz_hours_nxt   = (cur_hours == 5'd23) ? 5'd0 : cur_hours + 5'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!arm) begin
      state_nxt = DISARMED;
    end else begin
      case (state)
        DISARMED: state_nxt = ARMED;
        ARMED:    if (match_rise) state_nxt = RINGING;
        RINGING: begin
          if (stop)           state_nxt = ARMED;
          else if (snooze)    state_nxt = SNOOZE;
          else if (ring_done) state_nxt = ARMED;
        end
        SNOOZE: begin
          if (stop)            state_nxt = ARMED;
          else if (match_rise) state_nxt = RINGING;
        end
        default: state_nxt = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= DISARMED;
      match_q       <= 1'b0;
      ring_cnt      <= '0;
      snz_hours     <= 5'd0;
      snz_minutes   <= 6'd0;
      alarm_hours   <= 5'(DEFAULT_HOURS);
      alarm_minutes <= 6'(DEFAULT_MINUTES);
    end else begin
      state   <= state_nxt;
      match_q <= match;
      if (state_nxt == RINGING)
        ring_cnt <= (state == RINGING) ? ring_cnt + RING_WIDTH'(1) : '0;
      if (state == RINGING && state_nxt == SNOOZE) begin
        snz_hours   <= snz_hours_nxt;
        snz_minutes <= snz_minutes_nxt;
      end
      if (set_en && set_ok) begin
        alarm_hours   <= set_hours;
        alarm_minutes <= set_minutes;
      end
    end
  end

  assign start    = (state == RINGING);
  assign armed    = (state != DISARMED);
  assign snoozing = (state == SNOOZE);

endmodule
